// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: an independent registered TX serialiser and an RX deserialiser sharing clk/reset.
// Latency: TX line drops on the edge that takes start; RX valid ~154 cycles after the line falls (default rate). Backpressure: start is dropped while busy, RX never stalls.
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_tx_start,
    input  logic [7:0] uart_tx_input,
    output logic       uart_txd,
    output logic       uart_tx_busy,
    input  logic       uart_rxd,
    output logic [7:0] uart_rx_data,
    output logic       uart_valid,
    output logic       uart_err
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t       tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [2:0]      tx_idx, tx_idx_n;
    logic [7:0]      tx_dat, tx_dat_n;
    logic            txd_n, busy_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state     <= TX_IDLE;
            tx_cnt       <= '0;
            tx_idx       <= '0;
            tx_dat       <= '0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
        end else begin
            tx_state     <= tx_state_n;
            tx_cnt       <= tx_cnt_n;
            tx_idx       <= tx_idx_n;
            tx_dat       <= tx_dat_n;
            uart_txd     <= txd_n;
            uart_tx_busy <= busy_n;
        end
    end

    // Line and busy are decoded from the next state so they are registered yet change on the same edge.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_dat_n   = tx_dat;
        unique case (tx_state)
            TX_IDLE: begin
                if (uart_tx_start) begin
                    tx_dat_n   = uart_tx_input;
                    tx_cnt_n   = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_state_n = TX_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == 3'd7) tx_state_n = TX_STOP;
                    else                tx_idx_n   = tx_idx + 3'd1;
                end else begin
                    tx_cnt_n = tx_cnt + CNT_ONE;
                end
            end
            default: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + CNT_ONE;
                end
            end
        endcase

        txd_n  = 1'b1;
        busy_n = (tx_state_n != TX_IDLE);
        unique case (tx_state_n)
            TX_START: txd_n = 1'b0;
            TX_DATA:  txd_n = tx_dat_n[tx_idx_n];
            default:  txd_n = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic [1:0]      rx_sync;
    logic            rx_s;
    rx_state_t       rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_idx, rx_idx_n;
    logic [7:0]      rx_sh, rx_sh_n;
    logic [7:0]      rx_data_n;
    logic            valid_n, err_n;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync      <= 2'b11;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_sh        <= '0;
            uart_rx_data <= '0;
            uart_valid   <= 1'b0;
            uart_err     <= 1'b0;
        end else begin
            rx_sync      <= {rx_sync[0], uart_rxd};
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_idx       <= rx_idx_n;
            rx_sh        <= rx_sh_n;
            uart_rx_data <= rx_data_n;
            uart_valid   <= valid_n;
            uart_err     <= err_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_sh_n    = rx_sh;
        rx_data_n  = uart_rx_data;
        valid_n    = 1'b0;
        err_n      = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                // The detection cycle counts as the first of the half-bit wait.
                if (!rx_s) begin
                    rx_cnt_n   = CNT_ONE;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt >= HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_s, rx_sh[7:1]};
                    if (rx_idx == 3'd7) rx_state_n = RX_STOP;
                    else                rx_idx_n   = rx_idx + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    if (rx_s) begin
                        rx_data_n  = rx_sh;
                        valid_n    = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        err_n      = 1'b1;
                        rx_state_n = RX_BREAK;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + CNT_ONE;
                end
            end
            default: begin
                if (rx_s) rx_state_n = RX_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboarded bench for uart_transceiver: loopback frames, start-while-busy, framing error, glitch, mid-frame reset.
module tb_uart_transceiver;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_in;
    logic       txd, busy;
    logic       rxd, drv_rxd, loop;
    logic [7:0] rx_data;
    logic       valid, err;

    typedef struct { logic is_err; logic [7:0] dat; } ev_t;
    ev_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   t_fall = 0;
    bit   lat_armed = 1'b0;
    logic [7:0] model_dat = 8'h00;

    assign rxd = loop ? txd : drv_rxd;

    uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset),
        .uart_tx_start(tx_start), .uart_tx_input(tx_in),
        .uart_txd(txd), .uart_tx_busy(busy),
        .uart_rxd(rxd), .uart_rx_data(rx_data),
        .uart_valid(valid), .uart_err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: every cycle checks held data and exclusivity; pops the scoreboard on each pulse.
    always @(negedge clk) begin
        if (!reset) begin
            model_dat = 8'h00;
        end else begin
            chk("valid_err_excl", {31'b0, valid & err}, 32'd0);
            if (valid || err) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_evt", sb.size(), 32'd1);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("rx_kind_err", {31'b0, err}, {31'b0, e.is_err});
                    if (valid) model_dat = e.dat;
                    if (valid && lat_armed) begin
                        chk("rx_latency_ok", {31'b0, (cyc - t_fall) >= 153 && (cyc - t_fall) <= 155}, 32'd1);
                        lat_armed = 1'b0;
                    end
                end
            end
            chk("rx_data_hold", {24'b0, rx_data}, {24'b0, model_dat});
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_txd"},   {31'b0, txd},   32'd1);
        chk({tag, "_busy"},  {31'b0, busy},  32'd0);
        chk({tag, "_rxdat"}, {24'b0, rx_data}, 32'd0);
        chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
        chk({tag, "_err"},   {31'b0, err},   32'd0);
    endtask

    task automatic tx_frame(input logic [7:0] b, input bit inject);
        logic [9:0] fb;
        fb = {1'b1, b, 1'b0};
        @(negedge clk);
        tx_start = 1'b1;
        tx_in    = b;
        if (loop) sb.push_back('{1'b0, b});
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tx_start = 1'b0;
                tx_in    = ~b;
                if (loop) begin
                    t_fall    = cyc;
                    lat_armed = 1'b1;
                end
            end
            if (inject && k == 50) begin
                tx_start = 1'b1;
                tx_in    = 8'hA5;
            end
            if (inject && k == 51) tx_start = 1'b0;
            chk("tx_bit", {31'b0, txd}, {31'b0, fb[k / CPB]});
            chk("tx_busy_hi", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("tx_busy_end", {31'b0, busy}, 32'd0);
        chk("tx_idle_line", {31'b0, txd}, 32'd1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fb;
        fb = {stop_bit, b, 1'b0};
        if (stop_bit) sb.push_back('{1'b0, b});
        else          sb.push_back('{1'b1, 8'h00});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drv_rxd = fb[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        drv_rxd = 1'b1;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        tx_start = 1'b0;
        tx_in    = 8'h00;
        drv_rxd  = 1'b1;
        loop     = 1'b1;

        repeat (100) @(negedge clk);
        check_idle("rst_hold");
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_idle("rst_release");

        tx_frame(8'h34, 1'b0);
        wait_sb();
        tx_frame(8'h55, 1'b0);
        wait_sb();
        tx_frame(8'h34, 1'b1);
        repeat (40) @(negedge clk);
        wait_sb();

        loop = 1'b0;
        drive_frame(8'hFF, 1'b0);
        repeat (40) @(negedge clk);
        wait_sb();
        drive_frame(8'h0F, 1'b1);
        wait_sb();

        @(negedge clk);
        drv_rxd = 1'b0;
        repeat (3) @(negedge clk);
        drv_rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_evt", sb.size(), 32'd0);
        drive_frame(8'hC3, 1'b1);
        wait_sb();

        loop = 1'b1;
        @(negedge clk);
        tx_start = 1'b1;
        tx_in    = 8'h5A;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle("rst_midframe");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check_idle("post_abort");

        tx_frame(8'h81, 1'b0);
        wait_sb();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
